// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request per cycle to
// instruction memory, and buffers returned words with their PCs in a 2-entry queue.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPC,
    output logic              getInstruction,
    output logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    output logic              instrValid,
    input  logic              instrReady,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instrPC
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              kill;

    entry_t            head;
    entry_t            tail;
    logic [1:0]        count;

    entry_t            head_n;
    entry_t            tail_n;
    logic [1:0]        count_n;
    entry_t            new_entry;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        credit;

    assign instrValid = (count != 2'd0);
    assign pop        = instrValid & instrReady;

    // Slots already promised (queued + in flight) must leave room for this
    // request's response; a same-cycle pop frees one slot.
    assign credit = {1'b0, count} + {2'b00, inflight};
    assign issue  = rst_n & run & ~redirect & (credit < (3'd2 + {2'b00, pop}));

    assign getInstruction = issue;
    assign a              = pc;

    assign push      = inflight & ~kill & ~redirect;
    assign new_entry = '{instr: d, pc: req_pc};

    assign instr   = head.instr;
    assign instrPC = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else if (redirect) begin
            pc       <= {redirectPC[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
            kill     <= 1'b1;
        end else if (issue) begin
            pc       <= pc + STEP;
            req_pc   <= pc;
            inflight <= 1'b1;
            kill     <= 1'b0;
        end else begin
            inflight <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        if (redirect) begin
            count_n = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_n = new_entry;
                    else               tail_n = new_entry;
                    count_n = count + 2'd1;
                end
                2'b01: begin
                    head_n  = tail;
                    count_n = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_n = new_entry;
                    end else begin
                        head_n = tail;
                        tail_n = new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the queue storage is reset too, because the head drives instr/instrPC
    // and those must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects (incl. PC
// wrap), run drop, and mid-stream reset, against a word-k = 0x1000_0000+k memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        redirect;
    logic [7:0]  redirectPC;
    logic        getInstruction;
    logic [7:0]  a;
    logic [31:0] d;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [7:0]  instrPC;

    int n_checks = 0;
    int n_fail   = 0;

    logic       req_q;
    logic [7:0] addr_q;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .redirect       (redirect),
        .redirectPC     (redirectPC),
        .getInstruction (getInstruction),
        .a              (a),
        .d              (d),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .instr          (instr),
        .instrPC        (instrPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] addr);
        return 32'h1000_0000 + {24'd0, 2'b00, addr[7:2]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // End the current cycle; memory answers the request seen this cycle next cycle.
    task automatic tick();
        req_q  = getInstruction;
        addr_q = a;
        @(posedge clk);
        #1;
        d = req_q ? mem_word(addr_q) : 32'h0;
    endtask

    task automatic expect_head(input string tag, input logic [7:0] pc);
        check({tag, "_valid"}, instrValid, 1'b1);
        check({tag, "_pc"}, instrPC, pc);
        check({tag, "_instr"}, instr, mem_word(pc));
    endtask

    task automatic expect_req(input string tag, input logic [7:0] addr);
        check({tag, "_gi"}, getInstruction, 1'b1);
        check({tag, "_a"}, a, addr);
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b1;
        instrReady = 1'b1;
        redirect   = 1'b0;
        redirectPC = 8'h00;
        d          = 32'h0;
        #1;
        check("rst_valid", instrValid, 1'b0);
        check("rst_gi", getInstruction, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instrPC, 8'h00);
        tick();
        tick();

        // Phase A: streaming then 5 cycles of backpressure (cycles 3..7).
        rst_n = 1'b1;                                   // cycle 0
        #1; expect_req("a_c0", 8'h00); tick();
        #1; expect_req("a_c1", 8'h04);
        check("a_c1_valid", instrValid, 1'b0); tick();
        #1; expect_head("a_c2", 8'h00); expect_req("a_c2", 8'h08); tick();
        instrReady = 1'b0;                              // cycle 3
        #1; check("a_c3_gi", getInstruction, 1'b0); expect_head("a_c3", 8'h04); tick();
        for (int i = 4; i <= 7; i++) begin
            #1;
            check("a_stall_gi", getInstruction, 1'b0);
            expect_head("a_stall", 8'h04);
            tick();
        end
        instrReady = 1'b1;                              // cycle 8
        #1; expect_head("a_c8", 8'h04); expect_req("a_c8", 8'h0C); tick();
        #1; expect_head("a_c9", 8'h08); expect_req("a_c9", 8'h10); tick();
        #1; expect_head("a_c10", 8'h0C); expect_req("a_c10", 8'h14); tick();
        #1; expect_head("a_c11", 8'h10); expect_req("a_c11", 8'h18); tick();
        instrReady = 1'b0;                              // cycle 12: fill queue
        #1; check("a_c12_gi", getInstruction, 1'b0); expect_head("a_c12", 8'h14); tick();
        #1; check("full_gi", getInstruction, 1'b0); expect_head("full", 8'h14);

        // Mid-stream reset with the queue full: outputs drop at once.
        rst_n = 1'b0;
        #1;
        check("mrst_valid", instrValid, 1'b0);
        check("mrst_gi", getInstruction, 1'b0);
        check("mrst_instr", instr, 32'h0);
        check("mrst_pc", instrPC, 8'h00);
        tick();
        check("mrst_gi_hold", getInstruction, 1'b0);
        tick();

        // Phase B: restart, redirect to 0x40 at cycle 6, to 0xF9 at cycle 11.
        instrReady = 1'b1;
        rst_n      = 1'b1;                              // cycle 0
        #1; expect_req("b_c0", 8'h00); check("b_c0_valid", instrValid, 1'b0); tick();
        #1; check("b_c1_valid", instrValid, 1'b0); tick();
        for (int n = 2; n <= 5; n++) begin
            #1;
            expect_head("b_stream", 8'(4 * (n - 2)));
            tick();
        end
        redirect = 1'b1; redirectPC = 8'h40;            // cycle 6
        #1; check("rd1_gi", getInstruction, 1'b0); tick();
        redirect = 1'b0;
        #1; expect_req("rd1_c7", 8'h40); check("rd1_c7_valid", instrValid, 1'b0); tick();
        #1; expect_req("rd1_c8", 8'h44); check("rd1_c8_valid", instrValid, 1'b0); tick();
        #1; expect_head("rd1_c9", 8'h40); tick();
        #1; expect_head("rd1_c10", 8'h44); tick();
        redirect = 1'b1; redirectPC = 8'hF9;            // cycle 11
        #1; check("rd2_gi", getInstruction, 1'b0); expect_head("rd2_c11", 8'h48); tick();
        redirect = 1'b0;
        #1; expect_req("rd2_c12", 8'hF8); check("rd2_c12_valid", instrValid, 1'b0); tick();
        #1; expect_req("rd2_c13", 8'hFC); check("rd2_c13_valid", instrValid, 1'b0); tick();
        #1; expect_req("rd2_c14", 8'h00); expect_head("rd2_c14", 8'hF8); tick();
        #1; expect_req("rd2_c15", 8'h04); expect_head("rd2_c15", 8'hFC); tick();
        #1; expect_req("rd2_c16", 8'h08); expect_head("rd2_c16", 8'h00); tick();

        // Drop run with a request in flight; it still lands, then the queue drains.
        run = 1'b0; instrReady = 1'b0;                  // cycle 17
        #1; check("stop_c17_gi", getInstruction, 1'b0); expect_head("stop_c17", 8'h04); tick();
        #1; check("stop_c18_gi", getInstruction, 1'b0); expect_head("stop_c18", 8'h04); tick();
        instrReady = 1'b1;
        #1; check("stop_c19_gi", getInstruction, 1'b0); expect_head("stop_c19", 8'h04); tick();
        #1; check("stop_c20_gi", getInstruction, 1'b0); expect_head("stop_c20", 8'h08); tick();
        #1; check("stop_c21_gi", getInstruction, 1'b0); check("stop_c21_valid", instrValid, 1'b0); tick();
        #1; check("stop_c22_gi", getInstruction, 1'b0); check("stop_c22_valid", instrValid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction memory (`getInstruction` read port: strobe, 8-bit byte address, 32-bit word returned one clock later). It owns the program counter and issues one word request per cycle. It tags each returned word with its PC and buffers the word in a 2-entry queue. The word is then handed to decode over a valid/ready handshake, and the PC can be redirected on branches.

## Interface
- `ADDR_W`, 8, byte-address / PC width
- `DATA_W`, 32, instruction width
- `RESET_PC`, 8'h00, PC loaded on reset
- `PC_STEP`, 4, PC increment per fetched word
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  fetch enable; low = issue no new requests
- `redirect`  in  1  one-cycle pulse: load `redirectPC`, squash pending work
- `redirectPC`  in  ADDR_W  new PC (bits [1:0] ignored, treated as 0)
- `getInstruction`  out  1  memory read strobe, one request per high cycle
- `a`  out  ADDR_W  memory byte address, valid while `getInstruction`=1
- `d`  in  DATA_W  memory data, valid the cycle after a request
- `instrValid`  out  1  queue head holds a valid instruction
- `instrReady`  in  1  decode accepts head this cycle
- `instr`  out  DATA_W  head instruction
- `instrPC`  out  ADDR_W  PC of head instruction

## Operation
- State:
  - `pc` register.
  - `inflight` bit: a request was issued last cycle.
  - `reqPC` register: address of the in-flight request.
  - `kill` bit: drop the in-flight response.
  - 2-entry FIFO of {instr, PC} with `count` 0..2.
- pop = `instrValid` & `instrReady`; `instrValid` = (`count`≠0).
- Issue condition:
  - `getInstruction` = `run` & !`redirect` & (`count` + `inflight` − pop < 2).
  - Combinational from registers and these inputs; `a` = `pc`.
- On issue: `pc` ← `pc` + PC_STEP (mod 2^ADDR_W, so 8'hFC wraps to 8'h00), `reqPC` ← `pc`, `inflight` ← 1, `kill` ← 0. Otherwise `inflight` ← 0.
- Response:
  - In the cycle after issue, if `inflight` & !`kill` & !`redirect`, push {`d`, `reqPC`} at the clock edge.
  - Push and pop in the same cycle are both honoured (count unchanged).
  - The credit rule guarantees a push never finds the FIFO full.
- Redirect in cycle N:
  - `pc` ← `redirectPC` & ~3; FIFO flushed (`count` ← 0).
  - A response arriving in cycle N is dropped.
  - Any handshake in cycle N is discarded by the flush, and decode treats it as squashed.
  - No request is issued in cycle N. The first new-path request is in N+1.
- `run` low: no new requests. A request already in flight still completes and is buffered. Queued entries drain normally.
- Order: instructions leave in fetch order, with no duplication and no loss except through redirect or reset.
- Reset (asynchronous, any time):
  - `pc`=RESET_PC; `count`, `inflight`, `kill`, `reqPC` = 0.
  - Outputs: `getInstruction`=0, `instrValid`=0, `instr`=0, `instrPC`=0.
  - A response to a pre-reset request is ignored.
- `instr`/`instrPC` are 0 after reset. Otherwise they are don't-care while `instrValid`=0.

## Timing
- Request in cycle N → word sampled at the end of N+1 → `instrValid`=1 with that word in N+2. Request-to-output latency is 2 cycles.
- With `run`=1 and `instrReady`=1 held, throughput is 1 instruction/cycle. The first `getInstruction` occurs in the first cycle after reset release.
- Backpressure: with `instrReady`=0, at most 2 more requests are issued; then `getInstruction` stays 0 until a pop.
- Redirect latency: redirect in N → request at `redirectPC` in N+1 → output in N+3.
- Outputs `instrValid`/`instr`/`instrPC` are registered (FIFO head). `getInstruction`/`a` are registered `pc` gated by combinational issue logic.

## Test plan
- Reset, then `run`=1, `instrReady`=1, memory word k = 32'h1000_0000+k: `getInstruction`=1 from cycle 0 with `a`=0,4,8,…. Outputs begin cycle 2: (32'h10000000, PC 0), (32'h10000001, PC 4), … every cycle.
- Hold `instrReady`=0 for 5 cycles starting cycle 3: `count` reaches 2 and `getInstruction` drops. On release, the PC sequence continues with no gaps or repeats.
- Pulse `redirect` with `redirectPC`=8'h40 in cycle 6: no request in cycle 6, `a`=8'h40 in cycle 7, first output PC 8'h40 in cycle 9. No old-path PC appears after cycle 6.
- Redirect to 8'hF9: `a` sequence F8, FC, 00, 04; `instrPC` matches in order.
- Drop `run` while a request is in flight: that word is still delivered, and `getInstruction` stays 0 afterwards. The queue drains to `instrValid`=0.
- Assert `rst_n`=0 mid-stream with the FIFO full: `instrValid`, `getInstruction`, `instr`, `instrPC` go 0 immediately. After release, fetch restarts at PC 0 and no stale word is emitted.
